// File: rtl/skl_32_serial_8.sv
// Serial adder: one 8-bit Sklansky slice is reused over WIDTH/8 cycles,
// with the inter-slice carry held in a register between cycles.

module skl8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co
);
  logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
  logic [8:0] c;

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Sklansky prefix levels: at span 2^l, every bit with bit l of its index set
  // merges with the top bit of the block just below it.
  always_comb begin
    g1 = g0;
    p1 = p0;
    for (int i = 0; i < 8; i++) begin
      if (((i >> 0) & 1) == 1) begin
        g1[i] = g0[i] | (p0[i] & g0[((i >> 0) << 0) - 1]);
        p1[i] = p0[i] & p0[((i >> 0) << 0) - 1];
      end
    end
  end

  always_comb begin
    g2 = g1;
    p2 = p1;
    for (int i = 0; i < 8; i++) begin
      if (((i >> 1) & 1) == 1) begin
        g2[i] = g1[i] | (p1[i] & g1[((i >> 1) << 1) - 1]);
        p2[i] = p1[i] & p1[((i >> 1) << 1) - 1];
      end
    end
  end

  always_comb begin
    g3 = g2;
    p3 = p2;
    for (int i = 0; i < 8; i++) begin
      if (((i >> 2) & 1) == 1) begin
        g3[i] = g2[i] | (p2[i] & g2[((i >> 2) << 2) - 1]);
        p3[i] = p2[i] & p2[((i >> 2) << 2) - 1];
      end
    end
  end

  assign c   = {g3 | (p3 & {8{ci}}), ci};
  assign sum = p0 ^ c[7:0];
  assign co  = c[8];
endmodule

module skl_32_serial_8 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds data stable while valid is high and ready low.
  localparam int NS = WIDTH / 8;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, work, work_nxt;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [7:0]       slice_sum;
  logic             slice_co;
  logic             accept;

  skl8 u_slice (
    .a   (a_q[idx*8 +: 8]),
    .b   (b_q[idx*8 +: 8]),
    .ci  (carry),
    .sum (slice_sum),
    .co  (slice_co)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (idx == LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rst_n gates in_ready so it reads low while reset is held.
  always_comb begin
    in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    out_valid = (state == DONE);
    busy      = (state == RUN);
  end

  always_comb begin
    work_nxt = work;
    work_nxt[idx*8 +: 8] = slice_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      work  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_q   <= x1;
      b_q   <= x2;
      carry <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      work  <= work_nxt;
      carry <= slice_co;
      if (idx == LAST) begin
        s    <= work_nxt;
        cout <= slice_co;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_skl_32_serial_8.sv
// Bench for skl_32_serial_8: directed corner cases plus randomized streams
// checked against {cout,s} = x1 + x2 + cin.

module tb_skl_32_serial_8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] s;
  logic        cout;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [32:0] exp_q[$];

  skl_32_serial_8 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_s"}, 64'(s), 64'd0);
    check({tag, "_cout"}, 64'(cout), 64'd0);
  endtask

  // Send one op, wait for the result with out_ready low, check it, then consume.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input bit chk_lat);
    logic [32:0] e;
    int acc_cyc;
    int t;
    e = model(a, b, c);
    out_ready = 1'b0;
    in_valid = 1'b1; x1 = a; x2 = b; cin = c;
    t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    step();
    acc_cyc = cyc;
    in_valid = 1'b0; x1 = $urandom; x2 = $urandom; cin = 1'($urandom_range(0, 1));
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (chk_lat) check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd4);
    check({tag, "_s"}, 64'(s), 64'(e[31:0]));
    check({tag, "_cout"}, 64'(cout), 64'(e[32]));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // mode 0: valid/ready always high, spacing checked; mode 1: random stalls.
  task automatic stream(input int n, input int mode);
    int sent = 0;
    int got_n = 0;
    int last_acc = -1;
    int budget = 0;
    bit have = 0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c = 1'b0;
    logic [32:0] e;
    while (got_n < n && budget < 20000) begin
      if (!have && sent < n) begin
        a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1)); have = 1;
      end
      in_valid  = have && (mode == 0 || $urandom_range(0, 3) != 0);
      x1 = a; x2 = b; cin = c;
      out_ready = (mode == 0) || ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, c));
        if (mode == 0 && last_acc >= 0) check("spacing", 64'(cyc + 1 - last_acc), 64'd5);
        last_acc = cyc + 1;
        sent++;
        have = 0;
      end
      if (out_valid && out_ready) begin
        check("queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rand_s", 64'(s), 64'(e[31:0]));
          check("rand_cout", 64'(cout), 64'(e[32]));
        end
        got_n++;
      end
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_done", 64'(got_n), 64'(n));
  endtask

  initial begin
    logic [32:0] e;
    logic [32:0] e2;
    int t;

    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #4 rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    step();

    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    run_op("slice1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
    run_op("slice3", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("cin_only", 32'h0, 32'h0, 1'b1, 1'b0);
    run_op("msb_cin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);

    // backpressure: result held while out_ready low
    e = model(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
    in_valid = 1'b1; x1 = 32'hDEAD_BEEF; x2 = 32'h1357_9BDF; cin = 1'b1;
    step();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      x1 = $urandom;
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_s", 64'(s), 64'(e[31:0]));
      check("bp_cout", 64'(cout), 64'(e[32]));
      step();
    end
    e2 = model(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);
    in_valid = 1'b1; x1 = 32'h0F0F_0F0F; x2 = 32'hF0F0_F0F1; cin = 1'b0;
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b0; x1 = $urandom;
    check("release_busy", 64'(busy), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    check("release_s", 64'(s), 64'(e2[31:0]));
    check("release_cout", 64'(cout), 64'(e2[32]));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset in the second RUN cycle, with a nonzero previous result on s
    run_op("pre_rst", 32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0);
    in_valid = 1'b1; x1 = 32'hAAAA_AAAA; x2 = 32'h5555_5555; cin = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #5 rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", 64'(in_ready), 64'd1);
    step();
    run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);

    stream(20, 0);
    stream(1000, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/skl_32_serial_8.md
# skl_32_serial_8

Area-reduced 32-bit adder that time-multiplexes a single `skl8` Sklansky slice over four cycles instead of chaining four slices combinationally. It is the sequential companion to the ripple-of-Sklansky adders in the structured/rc family and is used by the PPA flow to trade latency for slice count. Operands arrive on a valid/ready input channel. The block feeds one 8-bit slice per cycle, with the registered carry, into its `skl8` instance. It returns the full sum on a valid/ready output channel.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. Must be a multiple of 8. `NS = WIDTH/8` slices.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `in_valid`, in, 1: operands valid.
- `in_ready`, out, 1: block can accept operands.
- `x1`, in, WIDTH: addend A.
- `x2`, in, WIDTH: addend B.
- `cin`, in, 1: carry-in.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts result.
- `s`, out, WIDTH: registered sum.
- `cout`, out, 1: registered carry-out.
- `busy`, out, 1: high in RUN.

## Operation

- One internal `skl8` instance. Its inputs are operand slice `idx` and the carry register; its 8-bit sum and cout are captured at each RUN edge.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid & in_ready`: latch `x1`, `x2`; load `carry<=cin` and `idx<=0`; go to RUN.
- RUN:
  - Each edge writes `work[8*idx+7:8*idx]` from the slice sum, sets `carry<=slice cout`, then increments `idx`.
  - The edge with `idx==NS-1` copies the completed `work` and the slice cout into `s`/`cout`, then goes to DONE.
- DONE:
  - `out_valid=1`; `s`/`cout` are held stable.
  - On `out_valid & out_ready`, go to IDLE.
  - If `in_valid` is also high in that cycle, accept new operands directly and go to RUN. `in_ready = IDLE | (DONE & out_ready)`.
- Input behaviour:
  - `in_valid` is ignored while `in_ready=0`.
  - Operands are sampled only at the accept edge. Later changes on `x1`/`x2`/`cin` do not affect the op in flight.
- Arithmetic: `{cout,s} = x1 + x2 + cin`, modulo 2^(WIDTH+1). There is no overflow flag.
- `s`/`cout` change only on the edge entering DONE. They keep the last result through IDLE until the next result lands.
- `idx` is `ceil(log2 NS)` bits and never wraps past NS-1.

## Timing

- Reset value of every output while `rst_n` is low:
  - `in_ready=0`: forced low during reset.
  - `out_valid=0`, `busy=0`, `s=0`, `cout=0`.
- Reset value of all internal registers while `rst_n` is low: `work=0`, `carry=0`, `idx=0`.
- First cycle after `rst_n` rises: `in_ready=1`.
- Latency: accept at edge T gives `out_valid` high after edge T+NS (T+4 for WIDTH=32).
- Throughput: one result per NS+1 cycles with `out_ready` held high.
- Backpressure: DONE holds indefinitely while `out_ready=0`. `s`, `cout` and `out_valid` stay unchanged, and no new operand is accepted.
- Reset asserted mid-RUN or in DONE: the result is discarded and all outputs are asynchronously cleared. No partial result is ever presented.
- Combinational paths: `out_ready -> in_ready` only. There is no `in_valid -> out_valid` path.

## Test plan

- Full carry ripple: x1=0xFFFFFFFF, x2=0x00000001, cin=0. Required: s=0x00000000, cout=1, `out_valid` rises exactly 4 cycles after accept.
- Inter-slice carry: x1=0x000000FF, x2=0x00000001, cin=0. Required: s=0x00000100, cout=0. Repeat with x1=0x00FFFFFF, which must give s=0x01000000.
- Carry-in only: x1=x2=0, cin=1. Required: s=0x00000001, cout=0. With x1=0x80000000, x2=0x80000000, cin=1, required: s=0x00000001, cout=1.
- Backpressure: complete one op, hold `out_ready=0` for 10 cycles while pulsing `in_valid` and changing `x1`. Required: s/cout/`out_valid` stable, `in_ready=0`, no accept. Releasing `out_ready` with `in_valid` high must accept in the same cycle.
- Reset mid-operation: assert `rst_n=0` at the second RUN cycle. Required: all outputs 0 immediately (asynchronously). After release, 0x12345678+0x11111111 must give s=0x23456789, cout=0.
- Random back-to-back: 1000 random ops with random `out_ready` stalls, checked against the behavioural `{cout,s}=x1+x2+cin`. Required: zero mismatches and 5-cycle spacing whenever `out_ready` is held high.
